// File: rtl/riscv_pkg.sv
// Shared RV32I load/store FUNCT3 codes, MEM-stage FSM encoding and byte-lane helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            default: bad = (a != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables, store-data replication, load extraction and extension.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and sign/zero extension for stores and loads
    always_comb begin
        o_be = byte_enable(i_funct3[1:0], i_addr_lo);

        case (i_funct3[1:0])
            2'b00:   o_wdata = {4{i_store_data[7:0]}};
            2'b01:   o_wdata = {2{i_store_data[15:0]}};
            default: o_wdata = i_store_data;
        endcase

        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            2'b11:   w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase

        // Without trapping, an odd half address still picks its lane from a[1] alone
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: req/ack data-memory bus sequencing, load capture, branch resolution.
// Optional MISALIGN_TRAP_EN: misaligned accesses are refused and flagged on misalign_err.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              Branch_MEM,
    input  logic              ZERO_MEM,
    input  logic [XLEN-1:0]   PC_MEM,
    input  logic [2:0]        FUNCT3_MEM,
    input  logic [XLEN-1:0]   ALU_OUT_MEM,
    input  logic [XLEN-1:0]   REG_DATA2_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              PCSrc,
    output logic [XLEN-1:0]   PC_Branch_out,
    output logic [XLEN-1:0]   READ_DATA_MEM,
    output logic              stall_mem
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    mem_state_e        r_state;
    mem_state_e        w_next_state;
    logic              w_access;
    logic              w_misalign;
    logic              w_start;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   r_read_data;

    assign w_access = MemRead_MEM | MemWrite_MEM;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(FUNCT3_MEM[1:0], ALU_OUT_MEM[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = w_access & ~w_misalign;

    load_store_align u_align (
        .i_funct3     (FUNCT3_MEM),
        .i_addr_lo    (ALU_OUT_MEM[1:0]),
        .i_store_data (REG_DATA2_MEM),
        .i_rdata      (dmem_rdata),
        .o_be         (dmem_be),
        .o_wdata      (dmem_wdata),
        .o_load_data  (w_load_data)
    );

    // Access sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; acks outside WAIT are ignored
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_next_state = WAIT;
                else         w_next_state = IDLE;
            end
            WAIT: begin
                if (dmem_ack) w_next_state = DONE;
                else          w_next_state = WAIT;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Load result register; stores leave it untouched, a trapped access clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data <= '0;
        end else if ((r_state == WAIT) && dmem_ack && !MemWrite_MEM) begin
            r_read_data <= w_load_data;
        end else if ((r_state == IDLE) && w_access && w_misalign) begin
            r_read_data <= '0;
        end else begin
            r_read_data <= r_read_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign_err;

    // One-cycle error pulse the cycle after a misaligned access is seen in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= (r_state == IDLE) & w_access & w_misalign;
        end
    end

    assign misalign_err = r_misalign_err;
`endif

    assign dmem_req      = (r_state == WAIT);
    assign dmem_we       = dmem_req & MemWrite_MEM;
    assign dmem_addr     = {ALU_OUT_MEM[ADDR_W-1:2], 2'b00};
    assign READ_DATA_MEM = r_read_data;
    // Gated by reset so the pipeline is released while the stage is held in reset
    assign stall_mem     = reset & w_start & (r_state != DONE);
    assign PCSrc         = Branch_MEM & ZERO_MEM;
    assign PC_Branch_out = PC_MEM;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of load/store vectors plus reset, branch and misalign sequences.
module tb_mem_access_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM, Branch_MEM, ZERO_MEM;
    logic [31:0] PC_MEM, ALU_OUT_MEM, REG_DATA2_MEM;
    logic [2:0]  FUNCT3_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        PCSrc;
    logic [31:0] PC_Branch_out, READ_DATA_MEM;
    logic        stall_mem;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead_MEM   (MemRead_MEM),
        .MemWrite_MEM  (MemWrite_MEM),
        .Branch_MEM    (Branch_MEM),
        .ZERO_MEM      (ZERO_MEM),
        .PC_MEM        (PC_MEM),
        .FUNCT3_MEM    (FUNCT3_MEM),
        .ALU_OUT_MEM   (ALU_OUT_MEM),
        .REG_DATA2_MEM (REG_DATA2_MEM),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .PCSrc         (PCSrc),
        .PC_Branch_out (PC_Branch_out),
        .READ_DATA_MEM (READ_DATA_MEM),
        .stall_mem     (stall_mem)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_err  (misalign_err)
`endif
    );

    typedef struct {
        logic [2:0]  f3;
        logic        st;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_wait;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_read;
        int          exp_stall;
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered #1 after a rising edge with the DUT in IDLE; returns #1 after the DONE->IDLE edge
    task automatic run_access(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata, input int ack_wait,
                              output int stalls, output logic [3:0] be, output logic [31:0] a,
                              output logic [31:0] wd, output logic we);
        int   waits;
        logic seen;
        logic done;
        waits = 0; seen = 1'b0; done = 1'b0; stalls = 0;
        be = 4'd0; a = 32'd0; wd = 32'd0; we = 1'b0;
        FUNCT3_MEM = f3; ALU_OUT_MEM = addr; REG_DATA2_MEM = sdata; dmem_rdata = rdata;
        MemWrite_MEM = st; MemRead_MEM = ~st; dmem_ack = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stall_mem) stalls++;
            if (dmem_req) begin
                if (!seen) begin
                    be = dmem_be; a = dmem_addr; wd = dmem_wdata; we = dmem_we; seen = 1'b1;
                end
                if (waits == ack_wait) dmem_ack = 1'b1;
                waits++;
            end else if (seen) begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: access did not complete within 20 cycles");
        end
        @(posedge clk); #1;
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        int          stalls;
        logic [3:0]  be;
        logic [31:0] a, wd;
        logic        we;

        //          f3     st    addr          sdata         rdata         ack be       exp_addr      exp_wdata     exp_read      stall
        vecs[0] = '{F3_B,  1'b0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 3};
        vecs[1] = '{F3_H,  1'b1, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'hFFFF_FF80, 2};
        vecs[2] = '{F3_HU, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_8001, 0, 4'b0011, 32'h0000_0000, 32'h0,        32'h0000_8001, 2};
        vecs[3] = '{F3_H,  1'b0, 32'h0000_0000, 32'h0,        32'h0000_8001, 0, 4'b0011, 32'h0000_0000, 32'h0,        32'hFFFF_8001, 2};
        vecs[4] = '{F3_BU, 1'b0, 32'h0000_0101, 32'h0,        32'h1234_F600, 2, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000_00F6, 4};
        vecs[5] = '{F3_W,  1'b1, 32'h0000_0030, 32'hDEAD_BEEF, 32'h5555_5555, 0, 4'b1111, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0000_00F6, 2};
        vecs[6] = '{F3_W,  1'b0, 32'h0000_0044, 32'h0,        32'h8765_4321, 0, 4'b1111, 32'h0000_0044, 32'h0,        32'h8765_4321, 2};
        vecs[7] = '{F3_B,  1'b1, 32'h0000_0007, 32'h1234_56A5, 32'hFFFF_FFFF, 1, 4'b1000, 32'h0000_0004, 32'hA5A5_A5A5, 32'h8765_4321, 3};
        vecs[8] = '{F3_HU, 1'b0, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 1, 4'b1100, 32'h0000_0000, 32'h0,        32'h0000_BEEF, 3};

        reset = 1'b0;
        MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; Branch_MEM = 1'b0; ZERO_MEM = 1'b0;
        PC_MEM = 32'd0; FUNCT3_MEM = F3_W; ALU_OUT_MEM = 32'd0; REG_DATA2_MEM = 32'd0;
        dmem_rdata = 32'd0; dmem_ack = 1'b0;

        @(negedge clk);
        check("rst_read_data", READ_DATA_MEM, 32'h0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall_mem}, 32'd0);
        MemRead_MEM = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].f3, vecs[i].st, vecs[i].addr, vecs[i].sdata, vecs[i].rdata,
                       vecs[i].ack_wait, stalls, be, a, wd, we);
            @(negedge clk);
            check($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, vecs[i].exp_be});
            check($sformatf("v%0d_addr", i), a, vecs[i].exp_addr);
            check($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].st});
            if (vecs[i].st) check($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wdata);
            else            check($sformatf("v%0d_unused_st", i), {31'd0, we}, 32'd0);
            check($sformatf("v%0d_read", i), READ_DATA_MEM, vecs[i].exp_read);
            check($sformatf("v%0d_stall", i), stalls, vecs[i].exp_stall);
            @(posedge clk); #1;
        end

        Branch_MEM = 1'b1; ZERO_MEM = 1'b1; PC_MEM = 32'h0000_0040;
        #1;
        check("br_taken", {31'd0, PCSrc}, 32'd1);
        check("br_target", PC_Branch_out, 32'h0000_0040);
        ZERO_MEM = 1'b0;
        #1;
        check("br_not_taken", {31'd0, PCSrc}, 32'd0);
        Branch_MEM = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while a load is waiting for its ack
        FUNCT3_MEM = F3_W; ALU_OUT_MEM = 32'h10; dmem_rdata = 32'h1111_2222; MemRead_MEM = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_wait_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b0; dmem_ack = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall_mem}, 32'd0);
        check("mid_rst_read", READ_DATA_MEM, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1; dmem_ack = 1'b0;
        #1;
        check("post_rst_idle_req", {31'd0, dmem_req}, 32'd0);
        check("post_rst_idle_stall", {31'd0, stall_mem}, 32'd1);
        MemRead_MEM = 1'b0;
        @(posedge clk); #1;
        run_access(F3_W, 1'b0, 32'h10, 32'h0, 32'hCAFE_0001, 0, stalls, be, a, wd, we);
        @(negedge clk);
        check("post_rst_read", READ_DATA_MEM, 32'hCAFE_0001);
        check("post_rst_stall", stalls, 2);
        @(posedge clk); #1;

`ifdef MISALIGN_TRAP_EN
        FUNCT3_MEM = F3_W; ALU_OUT_MEM = 32'h6; MemRead_MEM = 1'b1;
        @(negedge clk);
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_stall", {31'd0, stall_mem}, 32'd0);
        check("mis_err_before", {31'd0, misalign_err}, 32'd0);
        @(posedge clk); #1;
        MemRead_MEM = 1'b0;
        check("mis_err_pulse", {31'd0, misalign_err}, 32'd1);
        check("mis_read_zero", READ_DATA_MEM, 32'h0);
        check("mis_no_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        check("mis_err_cleared", {31'd0, misalign_err}, 32'd0);
        check("mis_still_idle", {31'd0, dmem_req}, 32'd0);
`else
        run_access(F3_H, 1'b0, 32'h3, 32'h0, 32'h8000_0000, 0, stalls, be, a, wd, we);
        @(negedge clk);
        check("odd_half_be", {28'd0, be}, 32'h0000_000C);
        check("odd_half_read", READ_DATA_MEM, 32'hFFFF_8000);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage fed by the EX/MEM pipeline register.
- Drives a request/acknowledge data-memory bus, generates byte enables and aligns store data.
- Extracts and sign- or zero-extends load data by FUNCT3.
- Resolves branches and stalls the upstream pipeline registers until the memory access completes.

Parameters:
- ADDR_W, 32, data-memory address width; low ADDR_W bits of ALU_OUT_MEM are used.
- XLEN, 32, data width; fixed at 32 for RV32I lane logic.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset; 0 = reset
- MemRead_MEM  in  1  load in MEM
- MemWrite_MEM  in  1  store in MEM
- Branch_MEM  in  1  branch in MEM
- ZERO_MEM  in  1  ALU zero flag
- PC_MEM  in  32  branch target
- FUNCT3_MEM  in  3  access size/sign
- ALU_OUT_MEM  in  32  effective address
- REG_DATA2_MEM  in  32  store data
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  ADDR_W  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read word
- dmem_ack  in  1  completion
- PCSrc  out  1  take branch
- PC_Branch_out  out  32  redirect target
- READ_DATA_MEM  out  32  extended load result, to MEM/WB
- stall_mem  out  1  hold upstream registers (write=0)
- misalign_err  out  1  only with MISALIGN_TRAP_EN

Behaviour:
- access = MemRead_MEM | MemWrite_MEM; MemWrite takes priority if both are set.
- FSM states IDLE, WAIT, DONE. Reset asynchronously forces IDLE, READ_DATA_MEM=0, dmem_req=0, misalign_err=0.
- IDLE: if access, go to WAIT at the next edge; otherwise stay.
- WAIT: dmem_req=1, with addr/be/we/wdata held stable. On dmem_ack, capture the extended load into READ_DATA_MEM (stores leave it unchanged) and go to DONE; otherwise stay.
- DONE: dmem_req=0; return to IDLE at the next edge.
- stall_mem = access & (state != DONE), combinational. Upstream advances at the end of DONE, so minimum access latency is 3 cycles (IDLE, WAIT with ack, DONE).
- If dmem_ack arrives in the first WAIT cycle, it is accepted. An ack outside WAIT is ignored.
- Reset mid-access: the request drops immediately and no data is captured.
- dmem_addr = {ALU_OUT_MEM[ADDR_W-1:2], 2'b00}.
- dmem_be by FUNCT3[1:0]:
  - 00 → 1 << a[1:0]
  - 01 → 0011 << {a[1],1'b0}
  - else → 1111
- Store data: dmem_wdata carries the byte replicated x4 or the half replicated x2; otherwise the full word.
- Load extraction uses the lane selected by a[1:0] (byte) or a[1] (half):
  - 000 lb: sign-extend byte
  - 001 lh: sign-extend half
  - 100 lbu: zero-extend byte
  - 101 lhu: zero-extend half
  - 010 and any other value: full word
- Branch resolution, combinational, independent of the FSM:
  - PCSrc = Branch_MEM & ZERO_MEM
  - PC_Branch_out = PC_MEM

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro defined, a misaligned access (half with a[0]=1, word with a[1:0]≠0) never leaves IDLE and never asserts dmem_req or stall_mem. misalign_err pulses high for one cycle (registered, the cycle after detection), READ_DATA_MEM is set to 0, and the store is suppressed.
- Without the macro, the misalign_err port is absent. Misaligned halves use a[1]; misaligned words ignore a[1:0].

Decomposition:
- Shared package riscv_pkg holds:
  - FUNCT3 load/store constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - FSM state encoding: IDLE=0, WAIT=1, DONE=2
- One natural sub-module: load_store_align (combinational lane steering, byte enables, extension).

Test Plan:
- lb from addr 0x103, rdata 0x80FF_0000, ack on the 2nd WAIT cycle → dmem_be=1000 during WAIT, READ_DATA_MEM=0xFFFF_FF80, stall_mem high for 3 cycles.
- sh of 0x1234_ABCD to addr 0x202, ack immediate → dmem_we=1, dmem_addr=0x200, dmem_be=1100, dmem_wdata=0xABCD_ABCD, stall for 2 cycles.
- lhu from 0x0, rdata 0x0000_8001 → READ_DATA_MEM=0x0000_8001; the same access as lh → 0xFFFF_8001.
- Branch_MEM=1, ZERO_MEM=1, PC_MEM=0x40 → PCSrc=1, PC_Branch_out=0x40 in the same cycle; ZERO_MEM=0 → PCSrc=0.
- reset driven to 0 while in WAIT → dmem_req=0, stall_mem=0 immediately; after release, state is IDLE and a subsequent load completes normally.
- With MISALIGN_TRAP_EN, lw at addr 0x6 → no dmem_req, misalign_err pulses 1 cycle, READ_DATA_MEM=0.
